// File: rtl/operand_pipe.sv
// Two-operand ALU (add/sub/and/xor) feeding a result FIFO with valid/ready on both sides.
// Define OPERAND_PIPE_SATURATE_EN to clamp add/sub results instead of wrapping.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module operand_pipe #(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] signal_1,
    input  logic [DATA_WIDTH-1:0] signal_2,
    input  logic [1:0]            op,
    output logic [DATA_WIDTH-1:0] signal_3,
    output logic                  ovf,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      count
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpAnd = 2'b10,
        OpXor = 2'b11
    } op_e;

    logic [DATA_WIDTH:0]   sum_ext;
    logic [DATA_WIDTH:0]   diff_ext;
    logic [DATA_WIDTH-1:0] res;
    logic                  res_ovf;

    logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push, pop;

    // Extra MSB captures carry (add) or borrow (sub).
    assign sum_ext  = {1'b0, signal_1} + {1'b0, signal_2};
    assign diff_ext = {1'b0, signal_1} - {1'b0, signal_2};

    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        unique case (op_e'(op))
            OpAdd: begin
                res_ovf = sum_ext[DATA_WIDTH];
`ifdef OPERAND_PIPE_SATURATE_EN
                res     = sum_ext[DATA_WIDTH] ? '1 : sum_ext[DATA_WIDTH-1:0];
`else
                res     = sum_ext[DATA_WIDTH-1:0];
`endif
            end
            OpSub: begin
                res_ovf = diff_ext[DATA_WIDTH];
`ifdef OPERAND_PIPE_SATURATE_EN
                res     = diff_ext[DATA_WIDTH] ? '0 : diff_ext[DATA_WIDTH-1:0];
`else
                res     = diff_ext[DATA_WIDTH-1:0];
`endif
            end
            OpAnd: res = signal_1 & signal_2;
            OpXor: res = signal_1 ^ signal_2;
            default: res = '0;
        endcase
    end

    assign in_ready  = (count_q != CNT_W'(FIFO_DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {res_ovf, res};
        end
    end

    assign signal_3 = out_valid ? mem_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
    assign ovf      = out_valid ? mem_q[rd_ptr_q][DATA_WIDTH] : 1'b0;
    assign count    = count_q;

endmodule

// File: tb/tb_operand_pipe.sv
// Directed self-checking bench for operand_pipe (DATA_WIDTH=8, FIFO_DEPTH=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_operand_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] signal_1;
    logic [7:0] signal_2;
    logic [1:0] op;
    logic [7:0] signal_3;
    logic       ovf;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;

    int errors = 0;
    int checks = 0;

    operand_pipe #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .signal_1 (signal_1),
        .signal_2 (signal_2),
        .op       (op),
        .signal_3 (signal_3),
        .ovf      (ovf),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        signal_1 = 8'h00;
        signal_2 = 8'h00;
        op = 2'b00;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: count=%0d out_valid=%b in_ready=%b, want 0 0 1",
                     count, out_valid, in_ready);
        end
        checks++;
        if (signal_3 !== 8'h00 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: signal_3=%h ovf=%b, want 00 0", signal_3, ovf);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: count=%0d out_valid=%b in_ready=%b, want 0 0 1",
                     count, out_valid, in_ready);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        signal_1 = 8'h12;
        signal_2 = 8'h34;
        op = 2'b00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (signal_3 !== 8'h46 || ovf !== 1'b0 || out_valid !== 1'b1 || count !== 3'd1) begin
            errors++;
            $display("FAIL latency: signal_3=%h ovf=%b out_valid=%b count=%0d, want 46 0 1 1",
                     signal_3, ovf, out_valid, count);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_pop: count=%0d out_valid=%b, want 0 0", count, out_valid);
        end
    endtask

    task automatic test_ops();
        logic [7:0] va [6];
        logic [7:0] vb [6];
        logic [1:0] vop [6];
        logic [7:0] vres [6];
        logic       vovf [6];
        va[0] = 8'hF0; vb[0] = 8'h20; vop[0] = 2'b00; vovf[0] = 1'b1;
        va[1] = 8'h05; vb[1] = 8'h07; vop[1] = 2'b01; vovf[1] = 1'b1;
        va[2] = 8'hF0; vb[2] = 8'h3C; vop[2] = 2'b10; vovf[2] = 1'b0; vres[2] = 8'h30;
        va[3] = 8'hFF; vb[3] = 8'h0F; vop[3] = 2'b11; vovf[3] = 1'b0; vres[3] = 8'hF0;
        va[4] = 8'h80; vb[4] = 8'h7F; vop[4] = 2'b00; vovf[4] = 1'b0; vres[4] = 8'hFF;
        va[5] = 8'h07; vb[5] = 8'h07; vop[5] = 2'b01; vovf[5] = 1'b0; vres[5] = 8'h00;
`ifdef OPERAND_PIPE_SATURATE_EN
        vres[0] = 8'hFF;
        vres[1] = 8'h00;
`else
        vres[0] = 8'h10;
        vres[1] = 8'hFE;
`endif
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            signal_1 = va[i];
            signal_2 = vb[i];
            op = vop[i];
            in_valid = 1'b1;
            out_ready = 1'b0;
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (signal_3 !== vres[i] || ovf !== vovf[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL op_%0d: signal_3=%h ovf=%b out_valid=%b, want %h %b 1",
                         i, signal_3, ovf, out_valid, vres[i], vovf[i]);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL ops_drain: count=%0d, want 0", count);
        end
    endtask

    task automatic test_full();
        logic [7:0] exp_q [5];
        int n = 0;
        for (int i = 0; i < 5; i++) exp_q[i] = 8'(i + 2);
        @(negedge clk);
        out_ready = 1'b0;
        op = 2'b00;
        signal_2 = 8'h01;
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            signal_1 = 8'(i);
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("FAIL full_after4: in_ready=%b count=%0d, want 0 4", in_ready, count);
        end
        signal_1 = 8'h05;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || count !== 3'd4 || signal_3 !== 8'h02) begin
            errors++;
            $display("FAIL full_hold: in_ready=%b count=%0d head=%h, want 0 4 02",
                     in_ready, count, signal_3);
        end
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            if (out_valid === 1'b1 && n < 5) begin
                checks++;
                if (signal_3 !== exp_q[n]) begin
                    errors++;
                    $display("FAIL drain_%0d: signal_3=%h, want %h", n, signal_3, exp_q[n]);
                end
                n++;
            end
            if (c == 0) out_ready = 1'b1;
            if (c == 1) begin
                checks++;
                if (count !== 3'd3 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL first_pop: count=%0d in_ready=%b, want 3 1", count, in_ready);
                end
            end
            if (c == 2) begin
                in_valid = 1'b0;
                checks++;
                if (count !== 3'd3) begin
                    errors++;
                    $display("FAIL fifth_accept: count=%0d, want 3", count);
                end
            end
        end
        out_ready = 1'b0;
        checks++;
        if (n !== 5 || count !== 3'd0) begin
            errors++;
            $display("FAIL drain_total: popped=%0d count=%0d, want 5 0", n, count);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        op = 2'b00;
        signal_2 = 8'h10;
        signal_1 = 8'h00;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            checks++;
            if (count !== 3'd1 || signal_3 !== 8'(c - 1 + 16)) begin
                errors++;
                $display("FAIL stream_%0d: count=%0d signal_3=%h, want 1 %h",
                         c, count, signal_3, 8'(c - 1 + 16));
            end
            if (c < 20) signal_1 = 8'(c);
            else in_valid = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: count=%0d out_valid=%b, want 0 0", count, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0;
        op = 2'b11;
        signal_2 = 8'hAA;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            signal_1 = 8'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || signal_3 !== 8'hAA) begin
            errors++;
            $display("FAIL pre_reset: count=%0d head=%h, want 3 aa", count, signal_3);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || signal_3 !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: count=%0d out_valid=%b in_ready=%b signal_3=%h, want 0 0 1 00",
                     count, out_valid, in_ready, signal_3);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        signal_1 = 8'h50;
        signal_2 = 8'h20;
        op = 2'b01;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (signal_3 !== 8'h30 || ovf !== 1'b0 || count !== 3'd1) begin
            errors++;
            $display("FAIL post_reset: signal_3=%h ovf=%b count=%0d, want 30 0 1",
                     signal_3, ovf, count);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ops();
        test_full();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
